truth_table_sweeper: RTL and testbench

//   Sequential stimulus/checker stage for 3-input synthesized logic circuits (NOR/NOT netlists).
//   - Upstream side: drives in1/in2/in3 through all 8 combinations.
//   - Downstream side: samples the circuit's combinational out and reconstructs its 8-bit truth-table code.
//   - Compares the code against an expected hex ID (e.g. 0xD9) and reports pass/fail plus a per-row mismatch mask.

---
 rtl/tt_sweep_pkg.sv | 20 ++
 rtl/tt_sync_chain.sv | 26 ++
 rtl/truth_table_sweeper.sv | 170 +++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM states, row count and
// the row-to-bit mapping used by both the design and its reference model.
package tt_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam int unsigned NUM_ROWS = 8;

    // Row 000 lands in the MSB of the code, row 111 in the LSB.
    function automatic logic [2:0] row_to_bit(input logic [2:0] row);
        return 3'd7 - row;
    endfunction

endpackage

// File: rtl/tt_sync_chain.sv
// Flop chain that brings the circuit-under-test output into the clk domain.
module tt_sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input circuit through all 8 input rows, rebuilds its truth-table
// code from the sampled output and compares it with the expected code.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter logic [7:0]  EXPECTED      = 8'hD9,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       dut_out_i,
    output logic       in1_o,
    output logic       in2_o,
    output logic       in3_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [7:0] captured_o,
    output logic [7:0] mismatch_mask_o
);

    localparam int unsigned CW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] SETTLE_ONE  = CW'(1);
    localparam logic [2:0]  LAST_ROW    = 3'(NUM_ROWS - 1);

    generate
        if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("SYNC_STAGES must be in 1..4");
        end
        if (SETTLE_CYCLES < SYNC_STAGES) begin : g_bad_settle
            $error("SETTLE_CYCLES must be >= SYNC_STAGES");
        end
    endgenerate

    state_t        state_q, state_d;
    logic [2:0]    row_q, row_d;
    logic [CW-1:0] settle_q, settle_d;
    logic [2:0]    stim_q, stim_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [7:0]    captured_q, captured_d;
    logic [7:0]    mask_q, mask_d;
    logic          dut_sync;

    tt_sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (dut_out_i),
        .q_o  (dut_sync)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        settle_d   = settle_q;
        stim_d     = stim_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        mask_d     = mask_q;
        captured_d = captured_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_APPLY;
                    row_d      = '0;
                    captured_d = '0;
                    busy_d     = 1'b1;
                end
            end
            ST_APPLY: begin
                stim_d   = row_q;
                settle_d = SETTLE_LOAD;
                state_d  = ST_WAIT;
                // A sweep restarted straight from FINISH skips IDLE, so clear here too.
                if (row_q == '0) begin
                    captured_d = '0;
                end
            end
            ST_WAIT: begin
                settle_d = settle_q - SETTLE_ONE;
                if (settle_q == SETTLE_ONE) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                captured_d[row_to_bit(row_q)] = dut_sync;
                if (row_q == LAST_ROW) begin
                    state_d = ST_FINISH;
                end else begin
                    row_d   = row_q + 3'd1;
                    state_d = ST_APPLY;
                end
            end
            ST_FINISH: begin
                done_d = 1'b1;
                pass_d = (captured_q == EXPECTED);
                mask_d = captured_q ^ EXPECTED;
                stim_d = '0;
                if (start_i) begin
                    state_d = ST_APPLY;
                    row_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                stim_d  = '0;
            end
        endcase

        if (abort_i) begin
            state_d    = ST_IDLE;
            row_d      = '0;
            settle_d   = '0;
            stim_d     = '0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            pass_d     = pass_q;
            mask_d     = mask_q;
            captured_d = captured_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            settle_q   <= '0;
            stim_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            captured_q <= '0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            settle_q   <= settle_d;
            stim_q     <= stim_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            captured_q <= captured_d;
            mask_q     <= mask_d;
        end
    end

    assign in1_o           = stim_q[2];
    assign in2_o           = stim_q[1];
    assign in3_o           = stim_q[0];
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign captured_o      = captured_q;
    assign mismatch_mask_o = mask_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboarded random bench for truth_table_sweeper with a NOR-netlist 0xD9 circuit.
module tb_truth_table_sweeper;
    import tt_sweep_pkg::*;

    localparam logic [7:0] EXP    = 8'hD9;
    localparam int         SETTLE = 4;
    localparam int         HOLD   = SETTLE + 2;
    localparam int         SWEEP  = 8 * HOLD + 1;

    typedef struct {
        int         cyc;
        logic [7:0] cap;
        logic [7:0] mask;
        logic       pass;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_i, start_i, abort_i, dut_out;
    logic       in1, in2, in3, busy, done, pass;
    logic [7:0] captured, mask;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         mode  = 0;
    logic [7:0] tbl   = '0;
    logic       last_pass = 1'b0;
    logic [7:0] last_mask = '0;
    exp_t       sb[$];

    logic na, nb, nc, ac, bc, t3, gate_f;

    truth_table_sweeper #(
        .EXPECTED     (EXP),
        .SETTLE_CYCLES(SETTLE),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .dut_out_i      (dut_out),
        .in1_o          (in1),
        .in2_o          (in2),
        .in3_o          (in3),
        .busy_o         (busy),
        .done_o         (done),
        .pass_o         (pass),
        .captured_o     (captured),
        .mismatch_mask_o(mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // f = b ? c : ~(a & c), built from NOR gates only
    assign na     = ~(in1 | in1);
    assign nb     = ~(in2 | in2);
    assign nc     = ~(in3 | in3);
    assign ac     = ~(na | nc);
    assign bc     = ~(nb | nc);
    assign t3     = ~(in2 | ac);
    assign gate_f = ~(~(bc | t3));

    always_comb begin
        dut_out = 1'b0;
        case (mode)
            0:       dut_out = gate_f;
            1:       dut_out = 1'b0;
            default: dut_out = tbl[row_to_bit({in1, in2, in3})];
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_code(input int m, input logic [7:0] t);
        if (m == 0) return EXP;
        if (m == 1) return 8'h00;
        return t;
    endfunction

    function automatic logic [2:0] model_stim(input int k);
        if (k <= 0 || k > 8 * HOLD) return 3'd0;
        return 3'((k - 1) / HOLD);
    endfunction

    task automatic push_exp(input int c, input logic [7:0] code, input logic b);
        exp_t e;
        e.cyc  = c;
        e.cap  = code;
        e.mask = code ^ EXP;
        e.pass = (code == EXP);
        e.busy = b;
        sb.push_back(e);
    endtask

    // monitor: every done pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (!rst_i && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("captured", {24'b0, captured}, {24'b0, e.cap});
                chk("pass", {31'b0, pass}, {31'b0, e.pass});
                chk("mismatch_mask", {24'b0, mask}, {24'b0, e.mask});
                chk("busy_at_done", {31'b0, busy}, {31'b0, e.busy});
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic run_sweep(input int m, input logic [7:0] t, input int abort_row, input int dup_k);
        logic [7:0] code;
        int a;
        code = model_code(m, t);
        mode = m;
        tbl  = t;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = cyc;
        start_i = 1'b0;
        chk("busy_on_accept", {31'b0, busy}, 32'd1);
        if (abort_row < 0) push_exp(a + SWEEP, code, 1'b0);
        for (int k = 1; k <= SWEEP; k++) begin
            @(negedge clk);
            start_i = (k == dup_k);
            if (abort_row >= 0 && k == HOLD * abort_row + 3) begin
                abort_i = 1'b0;
                chk("abort_busy", {31'b0, busy}, 32'd0);
                chk("abort_stim", {29'b0, in1, in2, in3}, 32'd0);
                chk("abort_captured", {24'b0, captured}, {24'b0, code & ~(8'hFF >> abort_row)});
                chk("abort_pass", {31'b0, pass}, {31'b0, last_pass});
                chk("abort_mask", {24'b0, mask}, {24'b0, last_mask});
                break;
            end
            chk("stim", {29'b0, in1, in2, in3}, {29'b0, model_stim(k)});
            if (abort_row >= 0 && k == HOLD * abort_row + 2) abort_i = 1'b1;
        end
        start_i = 1'b0;
        if (abort_row < 0) begin
            chk("busy_after_done", {31'b0, busy}, 32'd0);
            last_pass = (code == EXP);
            last_mask = code ^ EXP;
            idle(2);
        end else begin
            idle(SWEEP + 5);
        end
    endtask

    task automatic run_back_to_back(input logic [7:0] t);
        int a;
        mode = 2;
        tbl  = t;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = cyc;
        push_exp(a + SWEEP, t, 1'b1);
        push_exp(a + 2 * SWEEP, t, 1'b1);
        push_exp(a + 3 * SWEEP, t, 1'b0);
        for (int k = 1; k <= 3 * SWEEP; k++) begin
            @(negedge clk);
            if (k == 2 * SWEEP) start_i = 1'b0;
            chk("b2b_stim", {29'b0, in1, in2, in3}, {29'b0, model_stim(k % SWEEP)});
        end
        chk("b2b_busy_end", {31'b0, busy}, 32'd0);
        last_pass = (t == EXP);
        last_mask = t ^ EXP;
        idle(2);
    endtask

    task automatic run_reset_mid_row5();
        mode = 0;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        idle(5 * HOLD + 2);
        chk("pre_rst_stim", {29'b0, in1, in2, in3}, 32'd5);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_pass", {31'b0, pass}, 32'd0);
        chk("rst_captured", {24'b0, captured}, 32'd0);
        chk("rst_mask", {24'b0, mask}, 32'd0);
        chk("rst_stim", {29'b0, in1, in2, in3}, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        last_pass = 1'b0;
        last_mask = '0;
        idle(3);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         m, ab, dup;
        logic [7:0] t;
        rst_i   = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        idle(3);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_pass", {31'b0, pass}, 32'd0);
        chk("reset_captured", {24'b0, captured}, 32'd0);
        chk("reset_mask", {24'b0, mask}, 32'd0);
        chk("reset_stim", {29'b0, in1, in2, in3}, 32'd0);
        rst_i = 1'b0;
        idle(2);

        run_sweep(0, 8'h00, -1, -1);
        run_sweep(1, 8'h00, -1, -1);
        run_sweep(0, 8'h00, 3, -1);

        start_i = 1'b1;
        abort_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("start_abort_busy", {31'b0, busy}, 32'd0);
        idle(SWEEP + 3);
        chk("start_abort_stim", {29'b0, in1, in2, in3}, 32'd0);

        run_reset_mid_row5();
        run_sweep(0, 8'h00, -1, -1);
        run_sweep(0, 8'h00, -1, 20);
        run_back_to_back(8'($urandom));

        for (int i = 0; i < 12; i++) begin
            m   = int'($urandom_range(0, 2));
            t   = 8'($urandom);
            ab  = -1;
            dup = -1;
            if ($urandom_range(0, 3) == 0) ab = int'($urandom_range(0, 7));
            else if ($urandom_range(0, 2) == 0) dup = int'($urandom_range(2, 40));
            run_sweep(m, t, ab, dup);
        end

        idle(3);
        chk("pending_done", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
